// File: rtl/demux4_reg_if.sv
// rtl/demux4_reg_if.sv - handshake bundle between one producer and four consumer lanes
interface demux4_reg_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [1:0]   in_sel;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [W-1:0] out_data0;
  logic [W-1:0] out_data1;
  logic [W-1:0] out_data2;
  logic [W-1:0] out_data3;

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3
  );

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3
  );
endinterface

// File: rtl/demux4_reg.sv
// rtl/demux4_reg.sv - registered 1-to-4 demultiplexer with per-lane delivered-beat counters
module demux4_reg #(
  parameter int W  = 32,
  parameter int CW = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  demux4_reg_if.slave          bus,
  output logic [CW-1:0]        beat_cnt0,
  output logic [CW-1:0]        beat_cnt1,
  output logic [CW-1:0]        beat_cnt2,
  output logic [CW-1:0]        beat_cnt3
);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [W-1:0]        dreg_q, dreg_d;
  logic [1:0]          dest_q, dest_d;
  logic [3:0][CW-1:0]  cnt_q, cnt_d;

  logic       full;
  logic       drain;
  logic       load;
  logic [3:0] lane_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      dreg_q  <= '0;
      dest_q  <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dreg_q  <= dreg_d;
      dest_q  <= dest_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    full         = (state_q == FULL);
    // in_ready looks only at the held beat's lane so in_valid never loops back into it
    drain        = full & bus.out_ready[dest_q];
    bus.in_ready = ~full | bus.out_ready[dest_q];
    load         = bus.in_valid & bus.in_ready;

    state_d = state_q;
    dreg_d  = dreg_q;
    dest_d  = dest_q;

    case (state_q)
      EMPTY: if (load) state_d = FULL;
      FULL:  if (drain && !load) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase

    if (load) begin
      dreg_d = bus.in_data;
      dest_d = bus.in_sel;
    end

    lane_hit      = full ? (4'b0001 << dest_q) : 4'b0000;
    bus.out_valid = lane_hit;
    bus.out_data0 = lane_hit[0] ? dreg_q : '0;
    bus.out_data1 = lane_hit[1] ? dreg_q : '0;
    bus.out_data2 = lane_hit[2] ? dreg_q : '0;
    bus.out_data3 = lane_hit[3] ? dreg_q : '0;

    for (int n = 0; n < 4; n++) begin
      cnt_d[n] = cnt_q[n] + ((lane_hit[n] & bus.out_ready[n]) ? CW'(1) : CW'(0));
    end

    beat_cnt0 = cnt_q[0];
    beat_cnt1 = cnt_q[1];
    beat_cnt2 = cnt_q[2];
    beat_cnt3 = cnt_q[3];
  end

endmodule

// File: tb/tb_demux4_reg.sv
// tb/tb_demux4_reg.sv - directed self-checking bench for demux4_reg
module tb_demux4_reg;
  localparam int W  = 32;
  localparam int CW = 8;

  logic          clk;
  logic          reset;
  logic [CW-1:0] beat_cnt0, beat_cnt1, beat_cnt2, beat_cnt3;
  int            pass_cnt;
  int            total_cnt;

  demux4_reg_if #(.W(W)) bus ();

  demux4_reg #(.W(W), .CW(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .beat_cnt0 (beat_cnt0),
    .beat_cnt1 (beat_cnt1),
    .beat_cnt2 (beat_cnt2),
    .beat_cnt3 (beat_cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] lane_data(input int n);
    case (n)
      0: return bus.out_data0;
      1: return bus.out_data1;
      2: return bus.out_data2;
      default: return bus.out_data3;
    endcase
  endfunction

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;

    // reset with a beat offered: nothing may be captured
    reset         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'hDEADBEEF;
    bus.in_sel    = 2'd0;
    bus.out_ready = 4'b1111;
    tick();
    tick();
    check("rst_out_valid", 64'(bus.out_valid), 64'h0);
    check("rst_data0", 64'(bus.out_data0), 64'h0);
    check("rst_data1", 64'(bus.out_data1), 64'h0);
    check("rst_data2", 64'(bus.out_data2), 64'h0);
    check("rst_data3", 64'(bus.out_data3), 64'h0);
    check("rst_cnts", {32'h0, beat_cnt0, beat_cnt1, beat_cnt2, beat_cnt3}, 64'h0);
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'h1);

    // single beat to lane 2
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h12345678;
    bus.in_sel   = 2'd2;
    tick();
    bus.in_valid = 1'b0;
    #1;
    check("single_valid", 64'(bus.out_valid), 64'b0100);
    check("single_data2", 64'(bus.out_data2), 64'h12345678);
    check("single_data0", 64'(bus.out_data0), 64'h0);
    check("single_data3", 64'(bus.out_data3), 64'h0);
    tick();
    check("single_drained", 64'(bus.out_valid), 64'h0);
    check("single_cnt2", 64'(beat_cnt2), 64'd1);

    // backpressure on lane 1 with a second beat waiting
    bus.out_ready = 4'b1101;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'hA5A5A5A5;
    bus.in_sel    = 2'd1;
    tick();
    bus.in_data = 32'h5A5A5A5A;
    bus.in_sel  = 2'd3;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_in_ready", 64'(bus.in_ready), 64'h0);
      check("bp_data1", 64'(bus.out_data1), 64'hA5A5A5A5);
      check("bp_valid", 64'(bus.out_valid), 64'b0010);
      tick();
    end
    check("bp_cnt1_held", 64'(beat_cnt1), 64'd0);
    bus.out_ready = 4'b1111;
    #1;
    check("bp_release_ready", 64'(bus.in_ready), 64'h1);
    tick();
    bus.in_valid = 1'b0;
    #1;
    check("bp_cnt1", 64'(beat_cnt1), 64'd1);
    check("bp_new_valid", 64'(bus.out_valid), 64'b1000);
    check("bp_new_data3", 64'(bus.out_data3), 64'h5A5A5A5A);
    check("bp_data1_zero", 64'(bus.out_data1), 64'h0);
    tick();
    check("bp_cnt3", 64'(beat_cnt3), 64'd1);

    // full-throughput round robin, counters start at 0/1/1/1
    bus.out_ready = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'(i);
      bus.in_sel   = 2'(i % 4);
      #1;
      check("rr_in_ready", 64'(bus.in_ready), 64'h1);
      tick();
      check("rr_valid", 64'(bus.out_valid), 64'(4'b0001 << (i % 4)));
      check("rr_data", 64'(lane_data(i % 4)), 64'(i));
    end
    bus.in_valid = 1'b0;
    tick();
    check("rr_idle", 64'(bus.out_valid), 64'h0);
    check("rr_cnt0", 64'(beat_cnt0), 64'd2);
    check("rr_cnt1", 64'(beat_cnt1), 64'd3);
    check("rr_cnt2", 64'(beat_cnt2), 64'd3);
    check("rr_cnt3", 64'(beat_cnt3), 64'd3);

    // ready asserted only on lanes other than the held beat's lane
    bus.out_ready = 4'b0111;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'hCAFEF00D;
    bus.in_sel    = 2'd3;
    tick();
    bus.in_data = 32'h11111111;
    bus.in_sel  = 2'd0;
    for (int i = 0; i < 3; i++) begin
      check("wl_in_ready", 64'(bus.in_ready), 64'h0);
      check("wl_valid", 64'(bus.out_valid), 64'b1000);
      check("wl_cnt3", 64'(beat_cnt3), 64'd3);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'b1000;
    tick();
    check("wl_drained", 64'(bus.out_valid), 64'h0);
    check("wl_cnt3_after", 64'(beat_cnt3), 64'd4);
    check("wl_cnt0_same", 64'(beat_cnt0), 64'd2);

    // reset while a beat is stalled discards it and counts nothing
    bus.out_ready = 4'b0000;
    bus.in_valid  = 1'b1;
    bus.in_sel    = 2'd0;
    bus.in_data   = 32'h77777777;
    tick();
    check("mid_held", 64'(bus.out_valid), 64'b0001);
    reset         = 1'b1;
    bus.out_ready = 4'b1111;
    tick();
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus.out_valid), 64'h0);
    check("mid_rst_cnt0", 64'(beat_cnt0), 64'd0);
    check("mid_rst_data0", 64'(bus.out_data0), 64'h0);

    // 257 beats on lane 0 wraps the 8-bit counter to 1
    bus.in_valid = 1'b1;
    bus.in_sel   = 2'd0;
    for (int i = 0; i < 257; i++) begin
      bus.in_data = 32'(i);
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    check("wrap_cnt0", 64'(beat_cnt0), 64'd1);
    check("wrap_idle", 64'(bus.out_valid), 64'h0);
    check("wrap_cnt1", 64'(beat_cnt1), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
